// File: rtl/qam_tx_upsampler_if.sv
// Sample-path bundle for qam_tx_upsampler: symbol/sample enables, symbol
// data in, I/Q samples and status out. The master drives the inputs; the
// upsampler attaches as the slave.
interface qam_tx_upsampler_if #(
    parameter int WIDTH         = 18,
    parameter int BITS_PER_AXIS = 2,
    parameter int UPSAMPLE      = 4
);
    logic                          sym_clk_en;
    logic                          sam_clk_en;
    logic                          enable;
    logic                          hold_mode;
    logic [2*BITS_PER_AXIS-1:0]    data_in;
    logic signed [WIDTH-1:0]       i_out;
    logic signed [WIDTH-1:0]       q_out;
    logic [$clog2(UPSAMPLE)-1:0]   sam_phase;
    logic                          sym_strobe;
    logic                          sync_err;
    logic                          overrun;

    modport master (
        output sym_clk_en, sam_clk_en, enable, hold_mode, data_in,
        input  i_out, q_out, sam_phase, sym_strobe, sync_err, overrun
    );

    modport slave (
        input  sym_clk_en, sam_clk_en, enable, hold_mode, data_in,
        output i_out, q_out, sam_phase, sym_strobe, sync_err, overrun
    );
endinterface

// File: rtl/qam_tx_upsampler.sv
// QAM transmit mapper and upsampler. Each symbol is mapped to signed I/Q
// amplitudes, parked in a one-deep pending register, and released on the
// next sample enable. Between symbols it emits zeros (zero-stuff) or repeats
// the last sample (sample-and-hold).
// Optional build macro: QAM_GRAY_MAP_EN -- Gray-decode each axis field
// before mapping; when undefined the field is used as natural binary.
module qam_tx_upsampler #(
    parameter int WIDTH         = 18,
    parameter int BITS_PER_AXIS = 2,
    parameter int UPSAMPLE      = 4,
    parameter int SYM_MAG       = 98304
) (
    input  logic               clk,
    input  logic               reset_n,
    qam_tx_upsampler_if.slave  bus
);
    localparam int PH_W   = $clog2(UPSAMPLE);
    localparam int LEVELS = (1 << BITS_PER_AXIS) - 1;
    localparam int STEP   = SYM_MAG / LEVELS;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(UPSAMPLE - 1);

    logic signed [WIDTH-1:0] i_map;
    logic signed [WIDTH-1:0] q_map;
    logic signed [WIDTH-1:0] pend_i;
    logic signed [WIDTH-1:0] pend_q;
    logic                    pending;
    logic [PH_W-1:0]         phase_next;
    logic                    phase_wrap;

    // Axis field -> level index L.
    function automatic logic [BITS_PER_AXIS-1:0] axis_level(
        input logic [BITS_PER_AXIS-1:0] field
    );
`ifdef QAM_GRAY_MAP_EN
        logic [BITS_PER_AXIS-1:0] lvl;
        lvl[BITS_PER_AXIS-1] = field[BITS_PER_AXIS-1];
        for (int b = BITS_PER_AXIS - 2; b >= 0; b--) begin
            lvl[b] = lvl[b+1] ^ field[b];
        end
        return lvl;
`else
        return field;
`endif
    endfunction

    // Level index -> signed amplitude, (2L - LEVELS) * STEP at 64-bit precision.
    function automatic logic signed [WIDTH-1:0] axis_amp(
        input logic [BITS_PER_AXIS-1:0] field
    );
        longint lvl;
        longint prod;
        lvl  = longint'(axis_level(field));
        prod = (lvl + lvl - longint'(LEVELS)) * longint'(STEP);
        return prod[WIDTH-1:0];
    endfunction

    assign i_map = axis_amp(bus.data_in[2*BITS_PER_AXIS-1:BITS_PER_AXIS]);
    assign q_map = axis_amp(bus.data_in[BITS_PER_AXIS-1:0]);

    assign phase_wrap = (bus.sam_phase == PH_LAST);
    assign phase_next = phase_wrap ? '0 : bus.sam_phase + 1'b1;

    // Symbol capture, sample release, phase tracking and sticky status.
    // NOTE: every register here is assigned with <= so all updates see the
    // pre-edge values regardless of statement order inside the block.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.i_out      <= '0;
            bus.q_out      <= '0;
            bus.sam_phase  <= '0;
            bus.sym_strobe <= 1'b0;
            bus.sync_err   <= 1'b0;
            bus.overrun    <= 1'b0;
            pending        <= 1'b0;
            // NOTE: the pending sample register is reset too, so a symbol
            // captured before reset can never leak out afterwards.
            pend_i         <= '0;
            pend_q         <= '0;
        end else if (!bus.enable) begin
            bus.i_out      <= '0;
            bus.q_out      <= '0;
            bus.sam_phase  <= '0;
            bus.sym_strobe <= 1'b0;
            pending        <= 1'b0;
        end else begin
            bus.sym_strobe <= 1'b0;

            if (bus.sam_clk_en) begin
                if (pending || bus.sym_clk_en) begin
                    // A coincident new symbol wins over an older pending one.
                    bus.i_out      <= bus.sym_clk_en ? i_map : pend_i;
                    bus.q_out      <= bus.sym_clk_en ? q_map : pend_q;
                    bus.sam_phase  <= '0;
                    bus.sym_strobe <= 1'b1;
                end else begin
                    bus.sam_phase <= phase_next;
                    if (phase_wrap) begin
                        bus.sync_err <= 1'b1;
                    end
                    if (!bus.hold_mode) begin
                        bus.i_out <= '0;
                        bus.q_out <= '0;
                    end
                end
            end

            if (bus.sym_clk_en) begin
                pend_i <= i_map;
                pend_q <= q_map;
                if (pending && !bus.sam_clk_en) begin
                    bus.overrun <= 1'b1;
                end
            end

            pending <= !bus.sam_clk_en && (pending || bus.sym_clk_en);
        end
    end
endmodule

// File: tb/tb_qam_tx_upsampler.sv
// Directed, table-driven bench for qam_tx_upsampler at default parameters.
// Each table row is one clock: the inputs applied before the edge and the
// outputs expected just after it. A hand-written sequence covers the
// sync-error build-up and its stickiness.
module tb_qam_tx_upsampler;
    localparam int P3 = 98304;
    localparam int N3 = -98304;
    localparam int N1 = -32768;
`ifdef QAM_GRAY_MAP_EN
    localparam int GI = 98304;   // field 10 Gray-decodes to L=3
`else
    localparam int GI = 32768;   // field 10 is L=2
`endif
    localparam int GQ = -32768;  // field 01 is L=1 either way

    typedef struct {
        bit       rst_n;
        bit       en;
        bit       sym;
        bit       sam;
        bit       hold;
        bit [3:0] data;
        int       ei;
        int       eq;
        int       eph;
        bit       estb;
        bit       eserr;
        bit       eovr;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    qam_tx_upsampler_if #(.WIDTH(18), .BITS_PER_AXIS(2), .UPSAMPLE(4)) bus ();

    qam_tx_upsampler #(
        .WIDTH(18), .BITS_PER_AXIS(2), .UPSAMPLE(4), .SYM_MAG(98304)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string name, input int row, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %0d, expected %0d", name, row, act, exp);
        end
    endtask

    function automatic vec_t v(input bit rst_n, en, sym, sam, hold, input bit [3:0] data,
                               input int ei, eq, eph, input bit estb, eserr, eovr);
        vec_t r;
        r.rst_n = rst_n; r.en = en; r.sym = sym; r.sam = sam; r.hold = hold;
        r.data = data; r.ei = ei; r.eq = eq; r.eph = eph;
        r.estb = estb; r.eserr = eserr; r.eovr = eovr;
        return r;
    endfunction

    task automatic drive(input bit rst_n, en, sym, sam, hold, input bit [3:0] data);
        reset_n        = rst_n;
        bus.enable     = en;
        bus.sym_clk_en = sym;
        bus.sam_clk_en = sam;
        bus.hold_mode  = hold;
        bus.data_in    = data;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int row, input int ei, eq, eph, input bit estb, eserr, eovr);
        check("i_out",      row, longint'(bus.i_out),      longint'(ei));
        check("q_out",      row, longint'(bus.q_out),      longint'(eq));
        check("sam_phase",  row, longint'(bus.sam_phase),  longint'(eph));
        check("sym_strobe", row, longint'(bus.sym_strobe), longint'(estb));
        check("sync_err",   row, longint'(bus.sync_err),   longint'(eserr));
        check("overrun",    row, longint'(bus.overrun),    longint'(eovr));
    endtask

    initial begin
        //                 rst en sym sam hold data    i   q  ph stb serr ovr
        vecs.push_back(v(0, 0, 0, 0, 0, 4'h0,  0,  0,  0, 0, 0, 0)); // reset state
        vecs.push_back(v(1, 1, 1, 1, 0, 4'h3, N3, P3,  0, 1, 0, 0)); // zero-stuff symbol
        vecs.push_back(v(1, 1, 0, 0, 0, 4'h3, N3, P3,  0, 0, 0, 0)); // idle: no change
        vecs.push_back(v(1, 1, 0, 1, 0, 4'h3,  0,  0,  1, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 0, 4'h3,  0,  0,  2, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 0, 4'h3,  0,  0,  3, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 1, 1, 4'h3, N3, P3,  0, 1, 0, 0)); // hold symbol, no wrap err
        vecs.push_back(v(1, 1, 0, 1, 1, 4'h3, N3, P3,  1, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 1, 4'h3, N3, P3,  2, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 1, 4'h3, N3, P3,  3, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 4'h3, N3, P3,  3, 0, 0, 0)); // hold change waits for sam
        vecs.push_back(v(1, 1, 1, 1, 0, 4'h9, GI, GQ,  0, 1, 0, 0)); // axis mapping 10/01
        vecs.push_back(v(1, 1, 1, 0, 0, 4'h0, GI, GQ,  0, 0, 0, 0)); // pend 0000
        vecs.push_back(v(1, 1, 1, 0, 0, 4'hF, GI, GQ,  0, 0, 0, 1)); // overwrite -> overrun
        vecs.push_back(v(1, 1, 0, 1, 0, 4'hF, P3, P3,  0, 1, 0, 1)); // newest symbol out
        vecs.push_back(v(1, 1, 0, 1, 0, 4'hF,  0,  0,  1, 0, 0, 1));
        vecs.push_back(v(1, 1, 0, 1, 0, 4'hF,  0,  0,  2, 0, 0, 1));
        vecs.push_back(v(1, 1, 0, 1, 0, 4'hF,  0,  0,  3, 0, 0, 1));
        vecs.push_back(v(1, 1, 0, 1, 0, 4'hF,  0,  0,  0, 0, 1, 1)); // wrap w/o symbol
        vecs.push_back(v(1, 1, 0, 1, 0, 4'hF,  0,  0,  1, 0, 1, 1));
        vecs.push_back(v(1, 1, 1, 1, 0, 4'h5, N1, N1,  0, 1, 1, 1)); // inner points, sticky
        vecs.push_back(v(1, 1, 0, 1, 0, 4'h5,  0,  0,  1, 0, 1, 1));
        vecs.push_back(v(1, 1, 0, 1, 0, 4'h5,  0,  0,  2, 0, 1, 1));
        vecs.push_back(v(1, 0, 1, 1, 0, 4'hF,  0,  0,  0, 0, 1, 1)); // disable: enables ignored
        vecs.push_back(v(1, 1, 0, 1, 0, 4'hF,  0,  0,  1, 0, 1, 1)); // nothing was pending
        vecs.push_back(v(1, 1, 1, 1, 1, 4'hF, P3, P3,  0, 1, 1, 1));
        vecs.push_back(v(1, 1, 0, 1, 1, 4'hF, P3, P3,  1, 0, 1, 1));
        vecs.push_back(v(1, 1, 0, 1, 1, 4'hF, P3, P3,  2, 0, 1, 1));
        vecs.push_back(v(0, 1, 1, 1, 1, 4'hF,  0,  0,  0, 0, 0, 0)); // reset mid-symbol
        vecs.push_back(v(1, 1, 1, 0, 1, 4'h0,  0,  0,  0, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 1, 4'h0, N3, N3,  0, 1, 0, 0)); // first symbol at phase 0
        vecs.push_back(v(1, 1, 1, 0, 1, 4'h0, N3, N3,  0, 0, 0, 0)); // pend 0000
        vecs.push_back(v(1, 1, 1, 1, 1, 4'hF, P3, P3,  0, 1, 0, 0)); // coincident wins, no overrun
        vecs.push_back(v(1, 1, 0, 1, 1, 4'hF, P3, P3,  1, 0, 0, 0)); // pending was consumed

        bus.enable = 1'b0; bus.sym_clk_en = 1'b0; bus.sam_clk_en = 1'b0;
        bus.hold_mode = 1'b0; bus.data_in = '0; reset_n = 1'b0;
        @(posedge clk);
        #1;

        for (int r = 0; r < vecs.size(); r++) begin
            drive(vecs[r].rst_n, vecs[r].en, vecs[r].sym, vecs[r].sam, vecs[r].hold, vecs[r].data);
            check_all(r, vecs[r].ei, vecs[r].eq, vecs[r].eph,
                      vecs[r].estb, vecs[r].eserr, vecs[r].eovr);
        end

        // Sync error: five sample enables with no symbol, then a valid symbol.
        drive(0, 1, 0, 0, 0, 4'h0);
        check("sync_err after reset", 100, longint'(bus.sync_err), 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 1, 0, 4'h0);
            check("sync phase",   101 + k, longint'(bus.sam_phase), longint'((k + 1) % 4));
            check("sync_err seq", 101 + k, longint'(bus.sync_err),  (k >= 3) ? 1 : 0);
        end
        drive(1, 1, 1, 1, 0, 4'hC);
        check("sticky strobe",   110, longint'(bus.sym_strobe), 1);
        check("sticky i_out",    110, longint'(bus.i_out),      longint'(P3));
        check("sticky q_out",    110, longint'(bus.q_out),      longint'(N3));
        check("sticky sync_err", 110, longint'(bus.sync_err),   1);
        drive(1, 1, 0, 1, 0, 4'hC);
        check("sticky sync_err", 111, longint'(bus.sync_err),   1);
        drive(0, 1, 0, 0, 0, 4'h0);
        check("sync_err cleared", 112, longint'(bus.sync_err),  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
